// File: rtl/sw_ingress_port_if.sv
`default_nettype none
// ============================================================================
// Module   : sw_ingress_port_if
// Brief    : Upstream/downstream handshake bundle for the switch ingress port
// Revision : 1.0
// ============================================================================
interface sw_ingress_port_if #(
    parameter int DW = 4
);
    logic          validrx;
    logic [2:0]    adr_i;
    logic [DW-1:0] dat_i;
    logic          ackrx;
    logic          validtx;
    logic [2:0]    adr_o;
    logic [DW-1:0] dat_o;
    logic          acktx;

    // master: upstream device plus fabric sink; slave: the ingress port itself
    modport master (
        output validrx, adr_i, dat_i, acktx,
        input  ackrx, validtx, adr_o, dat_o
    );

    modport slave (
        input  validrx, adr_i, dat_i, acktx,
        output ackrx, validtx, adr_o, dat_o
    );
endinterface
`default_nettype wire

// File: rtl/sw_ingress_port.sv
`default_nettype none
// ============================================================================
// Module   : sw_ingress_port
// Brief    : Switch ingress port - filters illegal addresses into a show-ahead
//            FIFO toward the fabric, with saturating drop/forward counters
// Revision : 1.0
// ============================================================================
module sw_ingress_port #(
    parameter int DW    = 4,
    parameter int DEPTH = 4
) (
    input  wire                       clk_i,
    input  wire                       rst_i,
    sw_ingress_port_if.slave          bus,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [7:0]                err_cnt_o,
    output logic [7:0]                pkt_cnt_o
);
    localparam int               c_aw    = $clog2(DEPTH);
    localparam int               c_ew    = 3 + DW;
    localparam logic [c_aw:0]    c_depth = (c_aw + 1)'(DEPTH);

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [c_ew-1:0]     r_mem [DEPTH];
    logic [c_aw-1:0]     r_wptr;
    logic [c_aw-1:0]     r_rptr;
    logic [c_aw:0]       r_count;
    logic                r_ackrx;
    logic [7:0]          r_err_cnt;
    logic [7:0]          r_pkt_cnt;

    logic                w_xfer_in;
    logic                w_illegal;
    logic                w_push;
    logic                w_drop;
    logic                w_pop;
    logic [c_aw:0]       w_count_next;
    logic                w_ack_next;

    // Assert immediately, release two edges later so the first ack is delayed
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_xfer_in = bus.validrx & r_ackrx;
    assign w_illegal = (bus.adr_i[1:0] == 2'b11);
    assign w_push    = w_xfer_in & ~w_illegal;
    assign w_drop    = w_xfer_in & w_illegal;
    assign w_pop     = (r_count != '0) & bus.acktx;

    always_comb begin
        w_count_next = r_count + {{c_aw{1'b0}}, w_push} - {{c_aw{1'b0}}, w_pop};
        // A current ack blocks the next one, so each transfer is a single pulse
        w_ack_next   = bus.validrx & ~r_ackrx & (w_count_next < c_depth);
    end

    always_ff @(posedge clk_i or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ackrx   <= 1'b0;
            r_count   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_err_cnt <= '0;
            r_pkt_cnt <= '0;
        end else begin
            r_ackrx <= w_ack_next;
            r_count <= w_count_next;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_drop && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
            if (w_pop && (r_pkt_cnt != 8'hFF)) begin
                r_pkt_cnt <= r_pkt_cnt + 8'd1;
            end
        end
    end

    // Storage is left unreset; the occupancy count alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.adr_i, bus.dat_i};
        end
    end

    assign bus.ackrx                = r_ackrx;
    assign bus.validtx              = (r_count != '0);
    assign {bus.adr_o, bus.dat_o}   = r_mem[r_rptr];
    assign count_o                  = r_count;
    assign err_cnt_o                = r_err_cnt;
    assign pkt_cnt_o                = r_pkt_cnt;
endmodule
`default_nettype wire

// File: tb/tb_sw_ingress_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_ingress_port
// Brief    : Self-checking bench for sw_ingress_port (vector table, directed
//            corner cases, randomized traffic against a queue reference model)
// Revision : 1.0
// ============================================================================
module tb_sw_ingress_port;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] count;
    logic [7:0] err_cnt;
    logic [7:0] pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sw_ingress_port_if #(.DW(DW)) bus ();

    sw_ingress_port #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus),
        .count_o   (count),
        .err_cnt_o (err_cnt),
        .pkt_cnt_o (pkt_cnt)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model: queue of legal entries ----------------
    logic [DW+2:0] q[$];
    int            m_err;
    int            m_pkt;
    logic          m_ack;
    bit            mon_en      = 1'b0;
    bit            stream_mode = 1'b0;
    logic          m_old_ack;
    logic          m_in;
    logic          m_pop;

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_count", 32'(count), q.size());
            chk("mon_validtx", 32'(bus.validtx), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("mon_head_adr", 32'(bus.adr_o), 32'(q[0][DW+2:DW]));
                chk("mon_head_dat", 32'(bus.dat_o), 32'(q[0][DW-1:0]));
            end
            chk("mon_err_cnt", 32'(err_cnt), m_err);
            chk("mon_pkt_cnt", 32'(pkt_cnt), m_pkt);
            chk("mon_ackrx", 32'(bus.ackrx), 32'(m_ack));
            if (stream_mode) begin
                chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
            end
            // effects of the coming rising edge
            m_old_ack = m_ack;
            m_in      = bus.validrx & m_old_ack;
            m_pop     = (q.size() != 0) & bus.acktx;
            if (m_pop) begin
                void'(q.pop_front());
                if (m_pkt < 255) m_pkt++;
            end
            if (m_in) begin
                if (bus.adr_i[1:0] == 2'b11) begin
                    if (m_err < 255) m_err++;
                end else begin
                    q.push_back({bus.adr_i, bus.dat_i});
                end
            end
            m_ack = bus.validrx & ~m_old_ack & (q.size() < DEPTH);
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          v;
        logic [2:0]    a;
        logic [DW-1:0] d;
        logic          ak;
        logic          e_ack;
        logic          e_vtx;
        logic [2:0]    e_cnt;
        logic [2:0]    e_adr;
        logic [DW-1:0] e_dat;
        logic [7:0]    e_err;
        logic [7:0]    e_pkt;
    } vec_t;

    vec_t tbl[24];

    task automatic do_reset();
        bus.validrx = 1'b0;
        bus.acktx   = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // offer one transfer and hold it until acked; returns at posedge+2 after the transfer edge
    task automatic send(input logic [2:0] a, input logic [DW-1:0] d, output bit ok);
        bus.validrx = 1'b1;
        bus.adr_i   = a;
        bus.dat_i   = d;
        ok          = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.ackrx;
        end
        @(posedge clk);
        #2;
        chk("send_acked", 32'(ok), 32'd1);
    endtask

    logic [2:0]    ra;
    logic [DW-1:0] rd;
    bit            rok;
    bit            got;
    bit            done = 1'b0;

    initial begin
        tbl[0]  = '{1, 5, 4'hA, 0,  1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5, 4'hA, 0,  0, 1, 1, 5, 4'hA, 0, 0};
        tbl[2]  = '{0, 0, 0, 1,     0, 0, 0, 0, 0, 0, 1};
        tbl[3]  = '{1, 3, 7, 0,     1, 0, 0, 0, 0, 0, 1};
        tbl[4]  = '{1, 3, 7, 0,     0, 0, 0, 0, 0, 1, 1};
        tbl[5]  = '{0, 0, 0, 0,     0, 0, 0, 0, 0, 1, 1};
        tbl[6]  = '{1, 0, 1, 0,     1, 0, 0, 0, 0, 1, 1};
        tbl[7]  = '{1, 0, 1, 0,     0, 1, 1, 0, 1, 1, 1};
        tbl[8]  = '{1, 1, 2, 0,     1, 1, 1, 0, 1, 1, 1};
        tbl[9]  = '{1, 1, 2, 0,     0, 1, 2, 0, 1, 1, 1};
        tbl[10] = '{1, 2, 3, 0,     1, 1, 2, 0, 1, 1, 1};
        tbl[11] = '{1, 2, 3, 0,     0, 1, 3, 0, 1, 1, 1};
        tbl[12] = '{1, 4, 4, 0,     1, 1, 3, 0, 1, 1, 1};
        tbl[13] = '{1, 4, 4, 0,     0, 1, 4, 0, 1, 1, 1};
        tbl[14] = '{1, 5, 5, 0,     0, 1, 4, 0, 1, 1, 1};
        tbl[15] = '{1, 5, 5, 0,     0, 1, 4, 0, 1, 1, 1};
        tbl[16] = '{1, 5, 5, 1,     1, 1, 3, 1, 2, 1, 2};
        tbl[17] = '{1, 5, 5, 0,     0, 1, 4, 1, 2, 1, 2};
        tbl[18] = '{0, 0, 0, 0,     0, 1, 4, 1, 2, 1, 2};
        tbl[19] = '{0, 0, 0, 1,     0, 1, 3, 2, 3, 1, 3};
        tbl[20] = '{0, 0, 0, 1,     0, 1, 2, 4, 4, 1, 4};
        tbl[21] = '{0, 0, 0, 1,     0, 1, 1, 5, 5, 1, 5};
        tbl[22] = '{0, 0, 0, 1,     0, 0, 0, 0, 0, 1, 6};
        tbl[23] = '{0, 0, 0, 1,     0, 0, 0, 0, 0, 1, 6};

        // reset state
        rst_n       = 1'b0;
        bus.validrx = 1'b0;
        bus.adr_i   = '0;
        bus.dat_i   = '0;
        bus.acktx   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ackrx", 32'(bus.ackrx), 0);
        chk("rst_validtx", 32'(bus.validtx), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_err", 32'(err_cnt), 0);
        chk("rst_pkt", 32'(pkt_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single packet, illegal address, fill/backpressure, drain
        for (int i = 0; i < 24; i++) begin
            bus.validrx = tbl[i].v;
            bus.adr_i   = tbl[i].a;
            bus.dat_i   = tbl[i].d;
            bus.acktx   = tbl[i].ak;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_ackrx", i), 32'(bus.ackrx), 32'(tbl[i].e_ack));
            chk($sformatf("vec%0d_validtx", i), 32'(bus.validtx), 32'(tbl[i].e_vtx));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(tbl[i].e_err));
            chk($sformatf("vec%0d_pkt", i), 32'(pkt_cnt), 32'(tbl[i].e_pkt));
            if (tbl[i].e_vtx) begin
                chk($sformatf("vec%0d_adr", i), 32'(bus.adr_o), 32'(tbl[i].e_adr));
                chk($sformatf("vec%0d_dat", i), 32'(bus.dat_o), 32'(tbl[i].e_dat));
            end
        end

        // asynchronous reset with three entries queued
        bus.acktx = 1'b0;
        send(3'd6, 4'h1, rok);
        send(3'd2, 4'h2, rok);
        send(3'd0, 4'h3, rok);
        #1;
        chk("mid_count_pre", 32'(count), 3);
        chk("mid_err_pre", 32'(err_cnt), 1);
        chk("mid_pkt_pre", 32'(pkt_cnt), 6);
        bus.adr_i = 3'd6;
        bus.dat_i = 4'h9;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ackrx", 32'(bus.ackrx), 0);
        chk("mid_rst_validtx", 32'(bus.validtx), 0);
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_err", 32'(err_cnt), 0);
        chk("mid_rst_pkt", 32'(pkt_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ack_early", 32'(bus.ackrx), 0);
        chk("rel_no_stale", 32'(bus.validtx), 0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = bus.ackrx;
        end
        chk("rel_ack_seen", 32'(got), 1);
        @(posedge clk);
        #2;
        bus.validrx = 1'b0;
        @(negedge clk);
        chk("rel_count", 32'(count), 1);
        chk("rel_validtx", 32'(bus.validtx), 1);
        chk("rel_adr", 32'(bus.adr_o), 6);
        chk("rel_dat", 32'(bus.dat_o), 9);
        chk("rel_ack_single", 32'(bus.ackrx), 0);

        // saturation of the drop counter
        do_reset();
        bus.validrx = 1'b1;
        bus.adr_i   = 3'b111;
        bus.dat_i   = '0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("sat_err_mid", 32'(err_cnt), 100);
        chk("sat_pkt_mid", 32'(pkt_cnt), 0);
        repeat (440) @(posedge clk);
        @(negedge clk);
        chk("sat_err_held", 32'(err_cnt), 255);
        chk("sat_pkt", 32'(pkt_cnt), 0);
        chk("sat_count", 32'(count), 0);
        chk("sat_validtx", 32'(bus.validtx), 0);
        bus.validrx = 1'b0;

        // streaming with model checking every cycle
        do_reset();
        @(posedge clk);
        #2;
        q.delete();
        m_err       = 0;
        m_pkt       = 0;
        m_ack       = 1'b0;
        mon_en      = 1'b1;
        stream_mode = 1'b1;
        bus.acktx   = 1'b1;
        for (int k = 0; k < 10; k++) begin
            ra = 3'($urandom_range(0, 7));
            if (ra[1:0] == 2'b11) ra[1] = 1'b0;
            rd = DW'($urandom);
            send(ra, rd, rok);
        end
        bus.validrx = 1'b0;
        repeat (4) @(negedge clk);
        chk("stream_pkt", 32'(pkt_cnt), 10);
        chk("stream_count", 32'(count), 0);
        @(posedge clk);
        #2;
        stream_mode = 1'b0;

        // random traffic with random fabric backpressure
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    ra = 3'($urandom);
                    rd = DW'($urandom);
                    send(ra, rd, rok);
                    if ($urandom_range(0, 2) == 0) begin
                        bus.validrx = 1'b0;
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #2;
                    end
                end
                bus.validrx = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    bus.acktx = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #2;
                end
            end
        join
        bus.acktx = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        mon_en = 1'b0;
        chk("final_count", 32'(count), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
